// File: rtl/kbd_pkg.sv
// Shared definitions for the keyboard command decoder: ASCII codes, command table, run-state enum.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package kbd_pkg;

  // ASCII codes of the recognised command characters (uppercase table form)
  localparam logic [7:0] ASCII_E = 8'h45;
  localparam logic [7:0] ASCII_D = 8'h44;
  localparam logic [7:0] ASCII_B = 8'h42;
  localparam logic [7:0] ASCII_F = 8'h46;
  localparam logic [7:0] ASCII_R = 8'h52;

  // Lowercase letter range and the distance to its uppercase counterpart
  localparam logic [7:0] ASCII_LC_A = 8'h61;
  localparam logic [7:0] ASCII_LC_Z = 8'h7A;
  localparam logic [7:0] CASE_DELTA = 8'h20;

  // Command table slot order; slots at or above NUM_TABLE_CMDS carry no character
  localparam int IDX_E = 0;
  localparam int IDX_D = 1;
  localparam int IDX_B = 2;
  localparam int IDX_F = 3;
  localparam int IDX_R = 4;
  localparam int NUM_TABLE_CMDS = 5;
  localparam int MAX_CMDS = 16;

  typedef enum logic {
    ST_PAUSED  = 1'b0,
    ST_PLAYING = 1'b1
  } run_state_t;

  // Character held in table slot k (reserved slots return a dummy that is never matched)
  function automatic logic [7:0] cmd_char(input int k);
    case (k)
      IDX_E:   return ASCII_E;
      IDX_D:   return ASCII_D;
      IDX_B:   return ASCII_B;
      IDX_F:   return ASCII_F;
      IDX_R:   return ASCII_R;
      default: return 8'h00;
    endcase
  endfunction

  // True when slot k has a character assigned
  function automatic logic cmd_slot_used(input int k);
    return (k >= 0) && (k < NUM_TABLE_CMDS);
  endfunction

endpackage

// File: rtl/kbd_case_fold.sv
// Folds lowercase ASCII a-z onto A-Z when enabled; all other bytes pass through.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of the input byte.
module kbd_case_fold
  import kbd_pkg::*;
#(
  parameter int CASE_FOLD = 1
) (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Subtract the case offset only inside the lowercase letter range
  always_comb begin
    dout = din;
    if ((CASE_FOLD != 0) && (din >= ASCII_LC_A) && (din <= ASCII_LC_Z)) begin
      dout = din - CASE_DELTA;
    end
  end

endmodule

// File: rtl/kbd_cmd_decoder.sv
// Decodes keyboard ASCII strobes into command pulses, a play/pause FSM, direction and a counter.
// Latency: 2 clk edges from kbd_valid to outputs (capture stage, then output stage).
// Backpressure: none; every strobe is processed, back-to-back strobes included.
module kbd_cmd_decoder
  import kbd_pkg::*;
#(
  parameter int NUM_CMDS  = 5,
  parameter int CASE_FOLD = 1,
  parameter int HOLDOFF   = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          kbd_data,
  input  logic                kbd_valid,
  output logic [NUM_CMDS-1:0] cmd_pulse,
  output logic [3:0]          cmd_idx,
  output logic                unknown_pulse,
  output logic                playing,
  output logic                dir_fwd,
  output logic                restart_pulse,
  output logic [15:0]         accept_cnt
);

  // Holdoff counter must be able to hold HOLDOFF itself; one bit minimum when disabled
  localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLDOFF);

  // Capture stage
  logic                cap_vld_d, cap_vld_q;
  logic [7:0]          cap_dat_d, cap_dat_q;

  // Matching
  logic [7:0]          fold_dat;
  logic [NUM_CMDS-1:0] hit_vec;
  logic [3:0]          hit_idx;
  logic                hit_any;
  logic                repeat_hit;

  // Output stage and persistent state
  logic [NUM_CMDS-1:0] cmd_pulse_d, cmd_pulse_q;
  logic [3:0]          cmd_idx_d, cmd_idx_q;
  logic                unknown_pulse_d, unknown_pulse_q;
  logic                restart_pulse_d, restart_pulse_q;
  logic [15:0]         accept_cnt_d, accept_cnt_q;
  logic [HOLD_W-1:0]   hold_cnt_d, hold_cnt_q;
  logic                last_vld_d, last_vld_q;
  logic [3:0]          last_idx_d, last_idx_q;
  logic                dir_fwd_d, dir_fwd_q;
  run_state_t          state_d, state_q;

  // Capture next-state: the data register only loads on a strobe to avoid needless toggling
  always_comb begin
    cap_vld_d = kbd_valid;
    cap_dat_d = cap_dat_q;
    if (kbd_valid) begin
      cap_dat_d = kbd_data;
    end
  end

  // Capture registers; reset drops any byte in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_vld_q <= 1'b0;
      cap_dat_q <= 8'h00;
    end else begin
      cap_vld_q <= cap_vld_d;
      cap_dat_q <= cap_dat_d;
    end
  end

  kbd_case_fold #(
    .CASE_FOLD (CASE_FOLD)
  ) u_case_fold (
    .din  (cap_dat_q),
    .dout (fold_dat)
  );

  // Full 8-bit equality against each enabled table slot; table characters are unique
  always_comb begin
    hit_vec = '0;
    hit_idx = 4'd0;
    for (int k = 0; k < NUM_CMDS; k++) begin
      if (cmd_slot_used(k) && (fold_dat == cmd_char(k))) begin
        hit_vec[k] = 1'b1;
        hit_idx    = 4'(k);
      end
    end
  end

  assign hit_any    = |hit_vec;
  assign repeat_hit = last_vld_q && (last_idx_q == hit_idx) && (hold_cnt_q != '0);

  // Output-stage next-state: command accept/suppress/unknown handling and the run FSM
  always_comb begin
    cmd_pulse_d     = '0;
    unknown_pulse_d = 1'b0;
    restart_pulse_d = 1'b0;
    cmd_idx_d       = cmd_idx_q;
    accept_cnt_d    = accept_cnt_q;
    hold_cnt_d      = (hold_cnt_q != '0) ? (hold_cnt_q - HOLD_W'(1)) : '0;
    last_vld_d      = last_vld_q;
    last_idx_d      = last_idx_q;
    dir_fwd_d       = dir_fwd_q;
    state_d         = state_q;

    if (cap_vld_q) begin
      if (!hit_any) begin
        // Unrecognised byte breaks any repeat run but touches no latched state
        unknown_pulse_d = 1'b1;
        last_vld_d      = 1'b0;
        hold_cnt_d      = '0;
      end else if (repeat_hit) begin
        // Auto-repeat of the same key: swallow it and extend the window
        hold_cnt_d = HOLD_RELOAD;
      end else begin
        cmd_pulse_d  = hit_vec;
        cmd_idx_d    = hit_idx;
        accept_cnt_d = accept_cnt_q + 16'd1;
        hold_cnt_d   = HOLD_RELOAD;
        last_vld_d   = 1'b1;
        last_idx_d   = hit_idx;
        if (hit_idx == 4'(IDX_E)) begin
          state_d = ST_PLAYING;
        end
        if (hit_idx == 4'(IDX_D)) begin
          state_d = ST_PAUSED;
        end
        if (hit_idx == 4'(IDX_F)) begin
          dir_fwd_d = 1'b1;
        end
        if (hit_idx == 4'(IDX_B)) begin
          dir_fwd_d = 1'b0;
        end
        if (hit_idx == 4'(IDX_R)) begin
          restart_pulse_d = 1'b1;
        end
      end
    end
  end

  // Output-stage registers, FSM state register included
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_pulse_q     <= '0;
      cmd_idx_q       <= 4'd0;
      unknown_pulse_q <= 1'b0;
      restart_pulse_q <= 1'b0;
      accept_cnt_q    <= 16'd0;
      hold_cnt_q      <= '0;
      last_vld_q      <= 1'b0;
      last_idx_q      <= 4'd0;
      dir_fwd_q       <= 1'b1;
      state_q         <= ST_PAUSED;
    end else begin
      cmd_pulse_q     <= cmd_pulse_d;
      cmd_idx_q       <= cmd_idx_d;
      unknown_pulse_q <= unknown_pulse_d;
      restart_pulse_q <= restart_pulse_d;
      accept_cnt_q    <= accept_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      last_vld_q      <= last_vld_d;
      last_idx_q      <= last_idx_d;
      dir_fwd_q       <= dir_fwd_d;
      state_q         <= state_d;
    end
  end

  assign cmd_pulse     = cmd_pulse_q;
  assign cmd_idx       = cmd_idx_q;
  assign unknown_pulse = unknown_pulse_q;
  assign restart_pulse = restart_pulse_q;
  assign accept_cnt    = accept_cnt_q;
  assign dir_fwd       = dir_fwd_q;
  assign playing       = (state_q == ST_PLAYING);

endmodule

// File: tb/tb_kbd_cmd_decoder.sv
// Self-checking bench: scoreboarded main decoder (case folding, holdoff 10) plus an exact-match instance.
// Latency: expects outputs two clk edges after each strobe.
// Backpressure: none; stimulus is driven every cycle.
module tb_kbd_cmd_decoder;

  localparam int HO = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_a, data_b;
  logic       vld_a, vld_b;

  logic [4:0]  pulse_a, pulse_b;
  logic [3:0]  idx_a, idx_b;
  logic        unk_a, unk_b, play_a, play_b, dir_a, dir_b, rs_a, rs_b;
  logic [15:0] cnt_a, cnt_b;

  always #5 clk = ~clk;

  kbd_cmd_decoder #(.NUM_CMDS(5), .CASE_FOLD(1), .HOLDOFF(HO)) u_dut (
    .clk(clk), .rst_n(rst_n), .kbd_data(data_a), .kbd_valid(vld_a),
    .cmd_pulse(pulse_a), .cmd_idx(idx_a), .unknown_pulse(unk_a), .playing(play_a),
    .dir_fwd(dir_a), .restart_pulse(rs_a), .accept_cnt(cnt_a)
  );

  kbd_cmd_decoder #(.NUM_CMDS(5), .CASE_FOLD(0), .HOLDOFF(HO)) u_exact (
    .clk(clk), .rst_n(rst_n), .kbd_data(data_b), .kbd_valid(vld_b),
    .cmd_pulse(pulse_b), .cmd_idx(idx_b), .unknown_pulse(unk_b), .playing(play_b),
    .dir_fwd(dir_b), .restart_pulse(rs_b), .accept_cnt(cnt_b)
  );

  typedef struct {
    int unsigned tgt;
    logic [4:0]  pulse;
    logic [3:0]  idx;
    logic        unk;
    logic        play;
    logic        dir;
    logic        rs;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned edge_cnt = 0;
  int          checks = 0;
  int          failures = 0;

  // Reference model state
  logic        m_play, m_dir;
  logic [3:0]  m_idx;
  logic [15:0] m_cnt;
  int          m_hold;
  int          m_last;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_play = 1'b0;
    m_dir  = 1'b1;
    m_idx  = 4'd0;
    m_cnt  = 16'd0;
    m_hold = 0;
    m_last = -1;
  endtask

  // One model cycle: what the outputs must look like two edges after this drive
  task automatic model_push(input logic v, input logic [7:0] b);
    exp_t       e;
    logic [7:0] f;
    int         k;
    f = b;
    if (b >= 8'h61 && b <= 8'h7a) f = b - 8'h20;
    e.pulse = 5'd0;
    e.unk   = 1'b0;
    e.rs    = 1'b0;
    if (v) begin
      case (f)
        8'h45:   k = 0;
        8'h44:   k = 1;
        8'h42:   k = 2;
        8'h46:   k = 3;
        8'h52:   k = 4;
        default: k = -1;
      endcase
      if (k < 0) begin
        e.unk  = 1'b1;
        m_last = -1;
        m_hold = 0;
      end else if (k == m_last && m_hold > 0) begin
        m_hold = HO;
      end else begin
        e.pulse = 5'(1 << k);
        m_idx   = 4'(k);
        m_cnt   = m_cnt + 16'd1;
        m_hold  = HO;
        m_last  = k;
        if (f == 8'h45) m_play = 1'b1;
        if (f == 8'h44) m_play = 1'b0;
        if (f == 8'h46) m_dir = 1'b1;
        if (f == 8'h42) m_dir = 1'b0;
        if (f == 8'h52) e.rs = 1'b1;
      end
    end else if (m_hold > 0) begin
      m_hold = m_hold - 1;
    end
    e.idx  = m_idx;
    e.play = m_play;
    e.dir  = m_dir;
    e.cnt  = m_cnt;
    e.tgt  = edge_cnt + 2;
    sb.push_back(e);
  endtask

  task automatic step(input logic v, input logic [7:0] b);
    @(posedge clk); #1;
    vld_a  = v;
    data_a = v ? b : 8'h00;
    model_push(v, b);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pulse"}, 32'(pulse_a), 32'd0);
    chk({tag, "_idx"},   32'(idx_a),   32'd0);
    chk({tag, "_unk"},   32'(unk_a),   32'd0);
    chk({tag, "_play"},  32'(play_a),  32'd0);
    chk({tag, "_dir"},   32'(dir_a),   32'd1);
    chk({tag, "_rs"},    32'(rs_a),    32'd0);
    chk({tag, "_cnt"},   32'(cnt_a),   32'd0);
  endtask

  // Compare DUT outputs against the scoreboard entry due after this edge
  always @(negedge clk) begin
    if (rst_n === 1'b1 && sb.size() > 0 && sb[0].tgt == edge_cnt) begin
      mon_e = sb.pop_front();
      chk("cmd_pulse",     32'(pulse_a), 32'(mon_e.pulse));
      chk("cmd_idx",       32'(idx_a),   32'(mon_e.idx));
      chk("unknown_pulse", 32'(unk_a),   32'(mon_e.unk));
      chk("playing",       32'(play_a),  32'(mon_e.play));
      chk("dir_fwd",       32'(dir_a),   32'(mon_e.dir));
      chk("restart_pulse", 32'(rs_a),    32'(mon_e.rs));
      chk("accept_cnt",    32'(cnt_a),   32'(mon_e.cnt));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    vld_a  = 1'b0;
    data_a = 8'h00;
    vld_b  = 1'b0;
    data_b = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst_init");
    rst_n = 1'b1;

    // Lowercase 'e' folds to 'E': pulse bit0, playing, count 1
    step(1'b1, 8'h65);
    idle(14);

    // Holdoff: F at 0, F at 5 suppressed, F at 16 accepted
    step(1'b1, 8'h46);
    idle(4);
    step(1'b1, 8'h46);
    idle(10);
    step(1'b1, 8'h46);
    idle(12);

    // Back-to-back B then F
    step(1'b1, 8'h42);
    step(1'b1, 8'h46);
    idle(3);

    // Bytes that must not match: high-bit E, '[', '{'
    step(1'b1, 8'hC5);
    step(1'b1, 8'h5B);
    step(1'b1, 8'h7B);
    idle(2);

    // Repeat F inside window suppressed; an unknown byte then re-arms it
    step(1'b1, 8'h46);
    step(1'b1, 8'h46);
    step(1'b1, 8'h31);
    step(1'b1, 8'h46);
    idle(2);

    // Backward then restart while playing; then pause and a suppressed repeat pause
    step(1'b1, 8'h62);
    step(1'b1, 8'h72);
    idle(3);
    step(1'b1, 8'h44);
    step(1'b1, 8'h64);
    idle(2);

    // Accept E, then reset while the next strobe sits in the capture stage
    step(1'b1, 8'h45);
    idle(3);
    step(1'b1, 8'h42);
    @(posedge clk); #1;
    rst_n = 1'b0;
    vld_a = 1'b0;
    sb.delete();
    model_reset();
    @(posedge clk); #1;
    chk_reset_vals("rst_mid");
    rst_n = 1'b1;
    idle(4);

    // First strobe after reset is processed normally
    step(1'b1, 8'h45);
    idle(3);

    // Exact-match instance: 'E' accepted, 'e' unknown with state kept
    @(posedge clk); #1;
    vld_b  = 1'b1;
    data_b = 8'h45;
    @(posedge clk); #1;
    vld_b = 1'b0;
    @(posedge clk); #1;
    chk("exact_E_pulse", 32'(pulse_b), 32'd1);
    chk("exact_E_play",  32'(play_b),  32'd1);
    chk("exact_E_cnt",   32'(cnt_b),   32'd1);
    chk("exact_E_unk",   32'(unk_b),   32'd0);
    vld_b  = 1'b1;
    data_b = 8'h65;
    @(posedge clk); #1;
    vld_b = 1'b0;
    chk("exact_E_pulse_once", 32'(pulse_b), 32'd0);
    @(posedge clk); #1;
    chk("exact_e_unk",   32'(unk_b),   32'd1);
    chk("exact_e_pulse", 32'(pulse_b), 32'd0);
    chk("exact_e_play",  32'(play_b),  32'd1);
    chk("exact_e_cnt",   32'(cnt_b),   32'd1);
    chk("exact_e_idx",   32'(idx_b),   32'd0);
    @(posedge clk); #1;
    chk("exact_e_unk_once", 32'(unk_b), 32'd0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kbd_cmd_decoder.md
KBD_CMD_DECODER -- requirements
Module: kbd_cmd_decoder

Interface
REQ-001 SHALL have parameter NUM_CMDS, default 5, number of recognised command characters (1..16).
REQ-002 SHALL have parameter CASE_FOLD, default 1, meaning lowercase a-z matches its uppercase table entry.
REQ-003 SHALL have parameter HOLDOFF, default 1000, meaning repeat-suppression window in clk cycles (0 = disabled).
REQ-004 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port kbd_data  input  8  ASCII code from keyboard controller, synchronous to clk.
REQ-007 SHALL have port kbd_valid  input  1  one-cycle strobe qualifying kbd_data.
REQ-008 SHALL have port cmd_pulse  output  NUM_CMDS  one-hot, one-cycle pulse per accepted command.
REQ-009 SHALL have port cmd_idx  output  4  index of last accepted command, held between commands.
REQ-010 SHALL have port unknown_pulse  output  1  one-cycle pulse for a valid byte matching no entry.
REQ-011 SHALL have port playing  output  1  latched run state (1 = PLAYING).
REQ-012 SHALL have port dir_fwd  output  1  latched direction (1 = forward).
REQ-013 SHALL have port restart_pulse  output  1  one-cycle pulse on restart command.
REQ-014 SHALL have port accept_cnt  output  16  count of accepted commands.

Function
REQ-015 SHALL register kbd_data/kbd_valid in a capture stage at edge N and drive all outputs from a second register stage at edge N+1 (latency 2 edges, fixed).
REQ-016 SHALL fold 0x61..0x7A to 0x41..0x5A before comparison when CASE_FOLD=1; other bytes compared unchanged; CASE_FOLD=0 compares exact byte.
REQ-017 SHALL compare the full 8-bit folded byte for equality against each table entry; partial or masked matches SHALL NOT count.
REQ-018 SHALL, on match with entry k, assert cmd_pulse[k] for exactly one cycle, load cmd_idx=k, increment accept_cnt (wraps 0xFFFF->0x0000).
REQ-019 SHALL suppress a byte equal to the last accepted command while the holdoff counter is non-zero; suppressed byte reloads counter to HOLDOFF, produces no pulse, no count.
REQ-020 SHALL accept a different command immediately regardless of holdoff counter, reloading counter to HOLDOFF.
REQ-021 SHALL decrement holdoff counter by 1 per cycle when non-zero, saturating at 0.
REQ-022 SHALL, on unknown byte, pulse unknown_pulse one cycle, clear last-key memory and holdoff counter, leave all latched state unchanged.
REQ-023 SHALL run FSM states PAUSED and PLAYING: 'E' -> PLAYING, 'D' -> PAUSED, other commands hold state; playing = (state == PLAYING).
REQ-024 SHALL set dir_fwd=1 on 'F', dir_fwd=0 on 'B'; repeated same direction is a no-op on dir_fwd but still a normal accepted command.
REQ-025 SHALL pulse restart_pulse on 'R' without altering state or dir_fwd.
REQ-026 SHALL ignore kbd_data when kbd_valid=0; back-to-back strobes on consecutive cycles SHALL each be processed.
REQ-027 SHALL apply only table entries with index < NUM_CMDS; FSM/direction/restart actions apply only if their entry is enabled.

Reset
REQ-028 SHALL, on rst_n low, asynchronously clear: cmd_pulse=0, cmd_idx=0, unknown_pulse=0, restart_pulse=0, accept_cnt=0, holdoff counter=0, last-key memory invalid, capture stage invalid, state=PAUSED (playing=0), dir_fwd=1.
REQ-029 SHALL discard any byte in the capture stage when reset asserts mid-operation; first strobe after deassertion is processed normally.

Structure
REQ-030 SHALL place in shared package kbd_pkg: ASCII constants, command table order {0:'E',1:'D',2:'B',3:'F',4:'R'}, index constants, FSM state enum.
REQ-031 SHALL be one module with one natural sub-module kbd_case_fold (combinational byte folding).

Verification
REQ-032 SHALL cover: reset, strobe 0x65 ('e') -> 2 edges later cmd_pulse=5'b00001, playing=1, accept_cnt=1.
REQ-033 SHALL cover: HOLDOFF=10, 'F' at cycle 0 then 'F' at cycle 5 -> second suppressed, accept_cnt=1; 'F' at cycle 16 -> accepted, accept_cnt=2.
REQ-034 SHALL cover: 'B' then 'F' on consecutive cycles -> two pulses (bit2, bit3), dir_fwd final=1, cmd_idx=3.
REQ-035 SHALL cover: strobe 0x45 with CASE_FOLD=0 vs 0x65 -> 0x45 accepted, 0x65 gives unknown_pulse=1, state unchanged.
REQ-036 SHALL cover: 'E' accepted, rst_n low one cycle during next strobe -> playing=0, dir_fwd=1, accept_cnt=0, no pulses.
REQ-037 SHALL cover: 'R' while PLAYING/backward -> restart_pulse=1 one cycle, playing=1, dir_fwd=0 retained.
